reg_sel_decoder: RTL

- Decode side of the register-bus select path. The existing priority encoder turns one-hot register-out strobes into a 5-bit bus-mux select; this block goes the other way.
- Captures the instruction word and picks the Ra, Rb or Rc field. It decodes the 5-bit code into registered one-hot register-in and register-out enables for the 32-entry register file.
- Also provides a sweep sequencer that walks r0..r31 onto the bus one register per cycle, for debug dump and post-reset scrub.

---
 rtl/reg_sel_decoder_if.sv | 38 +++
 rtl/reg_sel_decoder.sv | 118 +++++++++++
 2 files changed

// File: rtl/reg_sel_decoder_if.sv
// Register-select bus bundle: IR load, field/strobe controls,
// sweep request, and the one-hot register enables coming back.
interface reg_sel_decoder_if #(
    parameter int SEL_W = 5,
    parameter int IR_W  = 32
);
    localparam int NREGS = 2 ** SEL_W;

    logic [IR_W-1:0]  ir_in;
    logic             ir_ld;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             rin;
    logic             rout;
    logic             ba_out;
    logic             sweep_req;
    logic [NREGS-1:0] reg_in;
    logic [NREGS-1:0] reg_out;
    logic             r0_zero;
    logic [SEL_W-1:0] sel_code;
    logic             busy;
    logic             sweep_done;

    modport master (
        output ir_in, ir_ld, gra, grb, grc,
        output rin, rout, ba_out, sweep_req,
        input  reg_in, reg_out, r0_zero,
        input  sel_code, busy, sweep_done
    );

    modport slave (
        input  ir_in, ir_ld, gra, grb, grc,
        input  rin, rout, ba_out, sweep_req,
        output reg_in, reg_out, r0_zero,
        output sel_code, busy, sweep_done
    );
endinterface

// File: rtl/reg_sel_decoder.sv
// Decodes IR register fields into registered one-hot register
// enables, with a sweep sequencer that walks r0..rN onto the bus.
module reg_sel_decoder #(
    parameter int SEL_W  = 5,
    parameter int IR_W   = 32,
    parameter int RA_LSB = 22,
    parameter int RB_LSB = 17,
    parameter int RC_LSB = 12
) (
    input logic              clock,
    input logic              clear_n,
    reg_sel_decoder_if.slave bus
);
    localparam int NREGS = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NREGS - 1);
    localparam logic [NREGS-1:0] ONE =
        {{(NREGS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [IR_W-1:0]  ir;
    logic [SEL_W-1:0] cnt, cnt_n, cnt_inc;
    logic [SEL_W-1:0] code;
    logic             valid;
    logic [NREGS-1:0] code_oh;
    logic [NREGS-1:0] in_n, out_n;
    logic [SEL_W-1:0] sel_n;
    logic             r0_n, busy_n, done_n;

    always_comb begin
        code  = ir[RC_LSB +: SEL_W];
        valid = 1'b1;
        priority case (1'b1)
            bus.gra: code = ir[RA_LSB +: SEL_W];
            bus.grb: code = ir[RB_LSB +: SEL_W];
            bus.grc: code = ir[RC_LSB +: SEL_W];
            default: valid = 1'b0;
        endcase
    end

    assign code_oh = ONE << code;
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        in_n    = '0;
        out_n   = '0;
        r0_n    = 1'b0;
        sel_n   = bus.sel_code;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                // sweep_req pre-empts any decode in the same cycle
                if (bus.sweep_req) begin
                    state_n = SWEEP;
                    cnt_n   = '0;
                    out_n   = ONE;
                    sel_n   = '0;
                    busy_n  = 1'b1;
                end else if (valid) begin
                    sel_n = code;
                    if (bus.rin)
                        in_n = code_oh;
                    if (bus.rout ||
                        (bus.ba_out && code != '0))
                        out_n = code_oh;
                    r0_n = bus.ba_out && !bus.rout &&
                           code == '0;
                end
            end
            SWEEP: begin
                if (cnt == LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt_inc;
                    out_n  = ONE << cnt_inc;
                    sel_n  = cnt_inc;
                    busy_n = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state          <= IDLE;
            cnt            <= '0;
            ir             <= '0;
            bus.reg_in     <= '0;
            bus.reg_out    <= '0;
            bus.r0_zero    <= 1'b0;
            bus.sel_code   <= '0;
            bus.busy       <= 1'b0;
            bus.sweep_done <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            if (bus.ir_ld)
                ir <= bus.ir_in;
            bus.reg_in     <= in_n;
            bus.reg_out    <= out_n;
            bus.r0_zero    <= r0_n;
            bus.sel_code   <= sel_n;
            bus.busy       <= busy_n;
            bus.sweep_done <= done_n;
        end
    end
endmodule
